switch_debounce: RTL and testbench

//   Front-end conditioning stage for the LED blinker, clocked at 25 kHz.

---
 rtl/led_blink_pkg.sv | 15 +
 rtl/debounce_channel.sv | 53 +++++
 rtl/switch_debounce.sv | 95 +++++++++
 tb/tb_switch_debounce.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared constants for the LED blinker front end: clock rate, debounce time
// and the derived default debounce limit.
package led_blink_pkg;

  localparam int c_CLK_HZ                 = 25000;
  localparam int c_DEBOUNCE_MS            = 10;
  localparam int c_DEFAULT_DEBOUNCE_LIMIT = c_CLK_HZ * c_DEBOUNCE_MS / 1000;
  localparam int c_DEFAULT_SYNC_STAGES    = 2;

  // Counter width able to hold 0 .. limit-1 (limit is always >= 2).
  function automatic int cnt_width(input int limit);
    return $clog2(limit);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: multi-flop synchroniser, stability counter and the
// accepted stable level q.
module debounce_channel
  import led_blink_pkg::*;
#(
  parameter int c_DEBOUNCE_LIMIT = c_DEFAULT_DEBOUNCE_LIMIT,
  parameter int c_SYNC_STAGES    = c_DEFAULT_SYNC_STAGES
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level
);

  localparam int                 c_CNT_W    = cnt_width(c_DEBOUNCE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DEBOUNCE_LIMIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_SYNC_STAGES-1:0] sync_r;
  logic                     sample_s;
  logic                     q_r;
  logic [c_CNT_W-1:0]       cnt_r;

  // Synchroniser shift chain; the oldest stage is the sample used below.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[c_SYNC_STAGES-2:0], i_raw};
    end
  end

  assign sample_s = sync_r[c_SYNC_STAGES-1];

  // Stability counter: any agreement with q restarts the count, so only an
  // unbroken run of disagreeing samples is accepted as a new level.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      q_r   <= 1'b0;
      cnt_r <= '0;
    end else if (sample_s == q_r) begin
      cnt_r <= '0;
    end else if (cnt_r == c_CNT_LAST) begin
      q_r   <= sample_s;
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + c_CNT_ONE;
    end
  end

  assign o_level = q_r;

endmodule

// File: rtl/switch_debounce.sv
// Debounced switch/enable front end for the LED blinker with a select-change
// pulse. Build option ENABLE_TOGGLE_EN turns the enable input into a toggle.
module switch_debounce
  import led_blink_pkg::*;
#(
  parameter int c_DEBOUNCE_LIMIT = c_DEFAULT_DEBOUNCE_LIMIT,
  parameter int c_SYNC_STAGES    = c_DEFAULT_SYNC_STAGES
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw_switch_1,
  input  logic i_raw_switch_2,
  input  logic i_raw_enable,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_enable,
  output logic o_sel_change
);

  logic q_sw1_s;
  logic q_sw2_s;
  logic q_en_s;
  logic sw1_d_r;
  logic sw2_d_r;
  logic sel_change_r;

  debounce_channel #(
    .c_DEBOUNCE_LIMIT (c_DEBOUNCE_LIMIT),
    .c_SYNC_STAGES    (c_SYNC_STAGES)
  ) u_ch_switch_1 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_raw   (i_raw_switch_1),
    .o_level (q_sw1_s)
  );

  debounce_channel #(
    .c_DEBOUNCE_LIMIT (c_DEBOUNCE_LIMIT),
    .c_SYNC_STAGES    (c_SYNC_STAGES)
  ) u_ch_switch_2 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_raw   (i_raw_switch_2),
    .o_level (q_sw2_s)
  );

  debounce_channel #(
    .c_DEBOUNCE_LIMIT (c_DEBOUNCE_LIMIT),
    .c_SYNC_STAGES    (c_SYNC_STAGES)
  ) u_ch_enable (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_raw   (i_raw_enable),
    .o_level (q_en_s)
  );

  // One pulse the cycle after either select level changes; a joint change
  // still yields a single pulse.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sw1_d_r      <= 1'b0;
      sw2_d_r      <= 1'b0;
      sel_change_r <= 1'b0;
    end else begin
      sw1_d_r      <= q_sw1_s;
      sw2_d_r      <= q_sw2_s;
      sel_change_r <= (q_sw1_s ^ sw1_d_r) | (q_sw2_s ^ sw2_d_r);
    end
  end

  assign o_switch_1   = q_sw1_s;
  assign o_switch_2   = q_sw2_s;
  assign o_sel_change = sel_change_r;

`ifdef ENABLE_TOGGLE_EN
  logic en_d_r;
  logic enable_r;

  // Flip on each debounced press; releases are ignored.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      en_d_r   <= 1'b0;
      enable_r <= 1'b0;
    end else begin
      en_d_r   <= q_en_s;
      enable_r <= enable_r ^ (q_en_s & ~en_d_r);
    end
  end

  assign o_enable = enable_r;
`else
  assign o_enable = q_en_s;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce (limit 4, 2 sync stages): table
// vectors, directed corner sequences and randomized stimulus vs a window model.
module tb_switch_debounce;

  localparam int LIMIT = 4;
  localparam int SYNC  = 2;
`ifdef ENABLE_TOGGLE_EN
  localparam int EN_LAT = 7;
`else
  localparam int EN_LAT = 6;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic raw_sw1 = 1'b0;
  logic raw_sw2 = 1'b0;
  logic raw_en  = 1'b0;
  logic o_sw1, o_sw2, o_en, o_sel;

  int n_cmp = 0;
  int n_err = 0;

  switch_debounce #(.c_DEBOUNCE_LIMIT(LIMIT), .c_SYNC_STAGES(SYNC)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_raw_switch_1 (raw_sw1),
    .i_raw_switch_2 (raw_sw2),
    .i_raw_enable   (raw_en),
    .o_switch_1     (o_sw1),
    .o_switch_2     (o_sw2),
    .o_enable       (o_en),
    .o_sel_change   (o_sel)
  );

  initial forever #5 clk = ~clk;

  // Reference model: a channel accepts a new level once the last LIMIT
  // synchronised samples (raw delayed by SYNC edges) all agree and differ from q.
  bit hist [3][$];
  bit mq   [3];
  bit mchg [3];
  bit m_sel;
  bit m_tog;

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      hist[c].delete();
      for (int i = 0; i < SYNC + LIMIT; i++) hist[c].push_back(1'b0);
      mq[c]   = 1'b0;
      mchg[c] = 1'b0;
    end
    m_sel = 1'b0;
    m_tog = 1'b0;
  endfunction

  function automatic void model_edge(input bit r0, input bit r1, input bit r2);
    bit rv [3];
    bit all_same;
    rv[0] = r0; rv[1] = r1; rv[2] = r2;
    m_sel = mchg[0] | mchg[1];
    if (mchg[2] && mq[2]) m_tog = !m_tog;
    for (int c = 0; c < 3; c++) begin
      hist[c].push_back(rv[c]);
      void'(hist[c].pop_front());
      all_same = 1'b1;
      for (int i = 0; i < LIMIT; i++) if (hist[c][i] != hist[c][0]) all_same = 1'b0;
      mchg[c] = all_same && (hist[c][0] != mq[c]);
      if (mchg[c]) mq[c] = hist[c][0];
    end
  endfunction

  function automatic bit model_en();
`ifdef ENABLE_TOGGLE_EN
    return m_tog;
`else
    return mq[2];
`endif
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    model_edge(raw_sw1, raw_sw2, raw_en);
    #1;
    check("model_sw1", o_sw1, mq[0]);
    check("model_sw2", o_sw2, mq[1]);
    check("model_en",  o_en,  model_en());
    check("model_sel", o_sel, m_sel);
  endtask

  task automatic check_zero(input string name);
    check({name, "_sw1"}, o_sw1, 1'b0);
    check({name, "_sw2"}, o_sw2, 1'b0);
    check({name, "_en"},  o_en,  1'b0);
    check({name, "_sel"}, o_sel, 1'b0);
  endtask

  // Called just after an edge; asserts reset, checks outputs clear at once and stay clear.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero("rst_now");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    rst = 1'b0;
  endtask

  typedef struct {
    logic sw1, sw2;
    logic e1, e2, es;
  } vec_t;
  vec_t tab[$];

  function automatic void add_row(input logic s1, input logic s2,
                                  input logic e1, input logic e2, input logic es);
    vec_t v;
    v.sw1 = s1; v.sw2 = s2; v.e1 = e1; v.e2 = e2; v.es = es;
    tab.push_back(v);
  endfunction

  // Eight-cycle hold: new level appears on row 6, select pulse on row 7.
  function automatic void add_seg(input logic s1, input logic s2,
                                  input logic p1, input logic p2);
    for (int r = 1; r <= 8; r++)
      add_row(s1, s2, (r >= 6) ? s1 : p1, (r >= 6) ? s2 : p2,
              (r == 7) && ((s1 != p1) || (s2 != p2)));
  endfunction

  initial begin
    bit bounce [5];
    bit nv;
    int hold;

    // Glitch: 3-cycle high on switch 1 is rejected.
    for (int i = 0; i < 3; i++) add_row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add_row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_seg(1'b1, 1'b0, 1'b0, 1'b0);  // clean edge on switch 1
    add_seg(1'b0, 1'b0, 1'b1, 1'b0);
    add_seg(1'b1, 1'b1, 1'b0, 1'b0);  // simultaneous rise
    add_seg(1'b0, 1'b0, 1'b1, 1'b1);  // simultaneous fall

    // Reset with all raw inputs high.
    raw_sw1 = 1'b1; raw_sw2 = 1'b1; raw_en = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_zero("rst_init");
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("rst_held");
    end
    raw_sw1 = 1'b0; raw_sw2 = 1'b0; raw_en = 1'b0;
    rst = 1'b0;

    foreach (tab[i]) begin
      raw_sw1 = tab[i].sw1;
      raw_sw2 = tab[i].sw2;
      tick();
      check("tab_sw1", o_sw1, tab[i].e1);
      check("tab_sw2", o_sw2, tab[i].e2);
      check("tab_sel", o_sel, tab[i].es);
    end

    // Bounce on switch 2, then a clean hold.
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      raw_sw2 = bounce[i];
      tick();
      check("bounce_sw2", o_sw2, 1'b0);
    end
    raw_sw2 = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("bounce_rise_sw2", o_sw2, t >= 6);
    end
    raw_sw2 = 1'b0;
    repeat (8) tick();

`ifdef ENABLE_TOGGLE_EN
    do_reset();
    for (int p = 0; p < 2; p++) begin
      raw_en = 1'b1;
      for (int t = 1; t <= 8; t++) begin
        tick();
        check("toggle_press", o_en, (t >= 7) ? (p == 0) : (p == 1));
      end
      raw_en = 1'b0;
      for (int t = 1; t <= 8; t++) begin
        tick();
        check("toggle_release", o_en, p == 0);
      end
    end
`endif

    // Reset in the middle of an enable count.
    raw_en = 1'b1;
    repeat (4) tick();
    do_reset();
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("rst_mid_en", o_en, t >= EN_LAT);
    end

    // Randomized holds of 1..7 cycles on every channel.
    for (int s = 0; s < 80; s++) begin
      nv = 1'($urandom_range(0, 1)); raw_sw1 = ($urandom_range(0, 2) == 0) ? raw_sw1 : nv;
      nv = 1'($urandom_range(0, 1)); raw_sw2 = ($urandom_range(0, 2) == 0) ? raw_sw2 : nv;
      nv = 1'($urandom_range(0, 1)); raw_en  = ($urandom_range(0, 2) == 0) ? raw_en  : nv;
      hold = int'($urandom_range(1, 7));
      repeat (hold) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
